// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM (Moore) with combinational ALU decoder.
// Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
module mips_mc_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   output logic       pc_en_o,
   output logic       iord_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_ctrl_o,
   output logic [1:0] pc_src_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);
   typedef enum logic [3:0] {
      RESET  = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
      MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
      ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
      JUMP   = 4'd12
   } state_e;
   state_e state_q, state_d;
   logic pc_write, branch, funct_ok;
   logic [2:0] alu_f;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= RESET;
      else        state_q <= state_d;
   always_comb begin
      alu_f    = 3'b010;
      funct_ok = 1'b1;
      case (funct_i)
         6'b100000: alu_f = 3'b010;
         6'b100010: alu_f = 3'b110;
         6'b100100: alu_f = 3'b000;
         6'b100101: alu_f = 3'b001;
         6'b101010: alu_f = 3'b111;
         default:   funct_ok = 1'b0;
      endcase
   end
   always_comb begin
      state_d      = FETCH;
      pc_write     = 1'b0;
      branch       = 1'b0;
      iord_o       = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_ctrl_o   = 3'b010;
      pc_src_o     = 2'b00;
      illegal_o    = 1'b0;
      case (state_q)
         RESET: state_d = FETCH;
         FETCH: begin
            ir_write_o  = 1'b1;
            alu_src_b_o = 2'b01;
            pc_write    = 1'b1;
            state_d     = DECODE;
         end
         DECODE: begin
            alu_src_b_o = 2'b11;
            if (op_i == OP_LW || op_i == OP_SW) state_d = MEMADR;
            else if (op_i == OP_RTYPE)          state_d = EXEC;
            else if (op_i == OP_BEQ)            state_d = BRANCH;
            else if (op_i == OP_ADDI)           state_d = ADDIEX;
            else if (op_i == OP_J)              state_d = JUMP;
            else                                illegal_o = 1'b1;
         end
         MEMADR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = (op_i == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord_o  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            mem_to_reg_o = 1'b1;
            reg_write_o  = 1'b1;
         end
         MEMWR: begin
            iord_o      = 1'b1;
            mem_write_o = 1'b1;
         end
         // an unknown funct still writes back: flagged, not trapped
         EXEC: begin
            alu_src_a_o = 1'b1;
            alu_ctrl_o  = alu_f;
            illegal_o   = ~funct_ok;
            state_d     = ALUWB;
         end
         ALUWB: begin
            reg_dst_o   = 1'b1;
            reg_write_o = 1'b1;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_ctrl_o  = 3'b110;
            pc_src_o    = 2'b01;
            branch      = 1'b1;
         end
         ADDIEX: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = ADDIWB;
         end
         ADDIWB: reg_write_o = 1'b1;
         JUMP: begin
            pc_src_o = 2'b10;
            pc_write = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end
   assign pc_en_o = pc_write | (branch & zero_i);
   assign state_o = state_q;
endmodule
